viterbi_frame_ctrl: RTL
=======================

// Module: viterbi_frame_ctrl
// PURPOSE
//  Frame sequencer for the rate-1/2, K=7 convolutional encoder / channel / Viterbi decoder path.
//  - Accepts a frame request.
//  - Streams frame_len source bits into the encoder, then TAIL zero bits to flush the trellis.
//  - Tracks decoder latency, marks which decoded bits belong to the frame, and signals completion.
//  - Sits between the stimulus source and the tx/rx chain; owns enable_encoder_i and the encoder input bit.
// PARAMETERS
//  LEN_W    8   width of frame length and bit counters (max frame 2**LEN_W-1 bits)
//  TAIL     6   flush bits appended per frame (K-1)
//  DEC_LAT  10  cycles from encoder input bit to its decoded bit at decoder_o (>=1)
// PORTS
//  clk             in   1      rising-edge clock
//  rst             in   1      synchronous reset, active-high
//  start_i         in   1      frame request, sampled in IDLE only
//  frame_len_i     in   LEN_W  data bits in frame, sampled with start_i
//  abort_i         in   1      abandon current frame
//  data_i          in   1      next source bit, consumed when data_req_o=1
//  data_req_o      out  1      data_i consumed this cycle
//  enable_encoder_o out 1      drives encoder enable
//  encoder_bit_o   out  1      drives encoder data input
//  decoder_bit_i   in   1      decoder output bit
//  out_bit_o       out  1      decoded frame bit (= decoder_bit_i when out_valid_o)
//  out_valid_o     out  1      out_bit_o is a frame data bit (tail bits never flagged)
//  busy_o          out  1      state != IDLE
//  done_o          out  1      one-cycle pulse, frame complete
//  aborted_o       out  1      one-cycle pulse, frame abandoned
//  out_count_o     out  LEN_W  decoded bits delivered in current/last frame
// BEHAVIOUR
//  States: IDLE, DATA, TAIL, DRAIN, DONE. On rst=1: state=IDLE; every output 0; counters 0; latency flags 0.
//  IDLE
//   - start_i=1, frame_len_i!=0: latch length, out_count_o<=0, go to DATA.
//   - start_i=1, frame_len_i==0: go to DONE directly; no encoder activity.
//  DATA (frame_len cycles)
//   - enable_encoder_o=1, encoder_bit_o=data_i, data_req_o=1.
//   - Go to TAIL after the frame_len-th bit.
//  TAIL (TAIL cycles)
//   - enable_encoder_o=1, encoder_bit_o=0, data_req_o=0.
//   - Go to DRAIN after the last tail bit.
//  DRAIN
//   - enable_encoder_o=0.
//   - Leave when all frame_len bits have been delivered.
//  DONE
//   - done_o=1 for exactly one cycle, then IDLE. out_count_o holds until the next accepted start.
//  Cycle timing
//   - Accept at cycle 0. enable_encoder_o high cycles 1..len+TAIL, contiguous, no gaps.
//  Latency tracking
//   - DEC_LAT-deep shift register of "data bit" flags, shifted every cycle.
//   - out_valid_o=1 exactly DEC_LAT cycles after each DATA cycle.
//   - out_bit_o=decoder_bit_i combinationally; it is 0 when out_valid_o=0.
//   - out_count_o increments on each out_valid_o.
//  DONE entry: the cycle after both (tail finished) and (out_count reached len).
//   - If DEC_LAT<=TAIL this is the cycle after the last tail bit.
//   - Otherwise it is the cycle after the final out_valid_o.
//  start_i while busy_o=1: ignored, no queueing.
//  abort_i in DATA/TAIL/DRAIN/DONE
//   - Next cycle: IDLE, aborted_o pulse, flag pipe cleared.
//   - No done_o. out_count_o keeps its partial value.
//   - Abort wins over a simultaneous DONE transition.
//  abort_i in IDLE: ignored. rst mid-frame: immediate return to reset values; no done_o or aborted_o.
//  Counters never wrap: frame_len <= 2**LEN_W-1.
// TESTING
//  1. len=4, bits 1,0,1,1, defaults -> enable cycles 1-10, encoder_bit 1,0,1,1 then six 0s; out_valid cycles 11-14; done_o at cycle 15.
//  2. DEC_LAT=2, len=3 -> out_valid cycles 3-5; done_o at cycle 10 (tail ends cycle 9).
//  3. frame_len_i=0 with start_i -> done_o at cycle 1; enable_encoder_o never high; out_count_o=0.
//  4. abort_i in cycle 3 of len=8 -> IDLE and aborted_o at cycle 4; no out_valid_o or done_o afterwards.
//  5. start_i held high through frame -> second frame starts only from IDLE after done_o; no overlap.
//  6. rst=1 at cycle 7 of len=20 -> all outputs 0 at cycle 8; a new start is accepted normally.

Source files
------------

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer: streams frame_len data bits plus TAIL flush zeros into the encoder and flags decoded frame bits.
// Latency: encoder enable from the cycle after start; out_valid_o DEC_LAT cycles after each data cycle; done_o after last bit.
// Backpressure: none; data_i is consumed every data_req_o cycle, start_i is ignored while busy.
module viterbi_frame_ctrl #(
    parameter int LEN_W   = 8,
    parameter int TAIL    = 6,
    parameter int DEC_LAT = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [LEN_W-1:0] frame_len_i,
    input  logic             abort_i,
    input  logic             data_i,
    output logic             data_req_o,
    output logic             enable_encoder_o,
    output logic             encoder_bit_o,
    input  logic             decoder_bit_i,
    output logic             out_bit_o,
    output logic             out_valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             aborted_o,
    output logic [LEN_W-1:0] out_count_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_TAIL,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_bit_cnt;
    logic [LEN_W-1:0]   r_out_count;
    logic [DEC_LAT-1:0] r_flags;
    logic               r_aborted;
    logic               w_valid;
    logic               w_len_done;
    logic               w_abort;

    assign w_valid    = r_flags[DEC_LAT-1];
    // Includes this cycle's decoded bit so DONE follows the final out_valid_o directly.
    assign w_len_done = (r_out_count + LEN_W'(w_valid)) == r_len;
    assign w_abort    = abort_i && (r_state != S_IDLE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_next = (frame_len_i == '0) ? S_DONE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_bit_cnt == r_len - 1'b1) begin
                    w_next = S_TAIL;
                end
            end
            S_TAIL: begin
                if (r_bit_cnt == LEN_W'(TAIL - 1)) begin
                    w_next = w_len_done ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_len_done) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_abort) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_bit_cnt   <= '0;
            r_out_count <= '0;
            r_flags     <= '0;
            r_aborted   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_aborted <= w_abort;
            r_flags   <= w_abort ? '0 : ((r_flags << 1) | DEC_LAT'(r_state == S_DATA));
            if (((r_state == S_DATA) || (r_state == S_TAIL)) && (w_next == r_state)) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end else begin
                r_bit_cnt <= '0;
            end
            if ((r_state == S_IDLE) && start_i) begin
                r_len       <= frame_len_i;
                r_out_count <= '0;
            end else if (w_valid) begin
                r_out_count <= r_out_count + 1'b1;
            end
        end
    end

    assign data_req_o       = (r_state == S_DATA);
    assign enable_encoder_o = (r_state == S_DATA) || (r_state == S_TAIL);
    assign encoder_bit_o    = (r_state == S_DATA) && data_i;
    assign out_valid_o      = w_valid;
    assign out_bit_o        = w_valid && decoder_bit_i;
    assign busy_o           = (r_state != S_IDLE);
    assign done_o           = (r_state == S_DONE) && !abort_i;
    assign aborted_o        = r_aborted;
    assign out_count_o      = r_out_count;

endmodule
